// File: rtl/display_pkg.sv
// Shared display timing definitions: default 640x480@60 mode, a timing struct for
// instantiators, and helpers that derive total line/frame lengths.
package display_pkg;

    localparam int unsigned DefClkDiv  = 4;
    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    localparam vga_timing_t Vga640x480 = '{
        h_active: 16'(DefHActive),
        h_fp:     16'(DefHFp),
        h_sync:   16'(DefHSync),
        h_bp:     16'(DefHBp),
        v_active: 16'(DefVActive),
        v_fp:     16'(DefVFp),
        v_sync:   16'(DefVSync),
        v_bp:     16'(DefVBp)
    };

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register with synchronous reset to a parameter value; DEPTH = 0 is a wire.
module vga_delay_line #(
    parameter int unsigned      WIDTH     = 3,
    parameter int unsigned      DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i, en_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d = stage_q;
            if (en_i) begin
                stage_d[0] = d_i;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= RESET_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel tick, coordinates, line/frame strobes and
// pipeline-aligned sync/de. Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt_o counter.
module vga_timing_gen
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV     = DefClkDiv,
    parameter int unsigned H_ACTIVE    = DefHActive,
    parameter int unsigned H_FP        = DefHFp,
    parameter int unsigned H_SYNC      = DefHSync,
    parameter int unsigned H_BP        = DefHBp,
    parameter int unsigned V_ACTIVE    = DefVActive,
    parameter int unsigned V_FP        = DefVFp,
    parameter int unsigned V_SYNC      = DefVSync,
    parameter int unsigned V_BP        = DefVBp,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned PIPE_STAGES = 0,
    localparam int unsigned X_W = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int unsigned Y_W = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic           clk_i,
    input  logic           rst_i,
    output logic           pixel_tick_o,
    output logic [X_W-1:0] pixel_x_o,
    output logic [Y_W-1:0] pixel_y_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt_o
`endif
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   H_DE_END = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   V_DE_END = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    // Idle pattern for {hsync, vsync, de}: syncs deasserted, blanking.
    localparam logic [2:0] SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0) begin : g_chk_h
        $error("vga_timing_gen: horizontal timing fields must be non-zero");
    end
    if (V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_chk_v
        $error("vga_timing_gen: vertical timing fields must be non-zero");
    end
    if (PIPE_STAGES > 8) begin : g_chk_pipe
        $error("vga_timing_gen: PIPE_STAGES must be in 0..8");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0]   h_q, h_d;
    logic [Y_W-1:0]   v_q, v_d;
    logic             tick;
    logic             hs_act, vs_act, de_raw;
    logic [2:0]       sync_raw, sync_dly;

    logic             pixel_tick_q, pixel_tick_d;
    logic [X_W-1:0]   pixel_x_q, pixel_x_d;
    logic [Y_W-1:0]   pixel_y_q, pixel_y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

    always_comb begin
        tick  = (div_q == DIV_MAX);
        div_d = tick ? '0 : div_q + DIV_W'(1);

        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + Y_W'(1);
            end else begin
                h_d = h_q + X_W'(1);
            end
        end

        hs_act   = (h_q >= HS_START) && (h_q < HS_END);
        vs_act   = (v_q >= VS_START) && (v_q < VS_END);
        de_raw   = (h_q < H_DE_END) && (v_q < V_DE_END);
        sync_raw = {hs_act ? HSYNC_POL : ~HSYNC_POL, vs_act ? VSYNC_POL : ~VSYNC_POL, de_raw};

        // Outputs present the counter value being consumed at this tick.
        pixel_tick_d  = tick;
        pixel_x_d     = tick ? h_q : pixel_x_q;
        pixel_y_d     = tick ? v_q : pixel_y_q;
        line_start_d  = tick && (h_q == '0);
        frame_start_d = line_start_d && (v_q == '0);
        {hsync_d, vsync_d, de_d} = tick ? sync_dly : {hsync_q, vsync_q, de_q};

`ifdef VGA_FRAME_CNT_EN
        frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
    end

    vga_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIPE_STAGES),
        .RESET_VAL(SYNC_IDLE)
    ) u_sync_dly (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (tick),
        .d_i  (sync_raw),
        .q_o  (sync_dly)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            pixel_tick_q  <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pixel_tick_q  <= pixel_tick_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign pixel_tick_o  = pixel_tick_q;
    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
`ifdef VGA_FRAME_CNT_EN
    assign frame_cnt_o   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a 16x8 small mode: dut_a (CLK_DIV=3, no pipe, active-low syncs)
// and dut_b (CLK_DIV=1, PIPE_STAGES=3, active-high syncs).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_tick, a_ls, a_fs, a_hs, a_vs, a_de;
    logic [3:0] a_x;
    logic [2:0] a_y;
    logic       b_tick, b_ls, b_fs, b_hs, b_vs, b_de;
    logic [3:0] b_x;
    logic [2:0] b_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] x;
        logic [2:0] y;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       de;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_STAGES(0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .pixel_tick_o(a_tick), .pixel_x_o(a_x), .pixel_y_o(a_y),
        .line_start_o(a_ls), .frame_start_o(a_fs), .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt_o(a_fc)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_STAGES(3)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .pixel_tick_o(b_tick), .pixel_x_o(b_x), .pixel_y_o(b_y),
        .line_start_o(b_ls), .frame_start_o(b_fs), .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt_o(b_fc)
`endif
    );

    // Expected outputs at the k-th tick after reset; syncs/de lag by pipe ticks.
    function automatic exp_t model(input int k, input int pipe, input bit pol);
        exp_t e;
        int h, v, d, hh, vv;
        h    = k % 16;
        v    = (k / 16) % 8;
        e.x  = 4'(h);
        e.y  = 3'(v);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        if (k < pipe) begin
            e.hs = !pol;
            e.vs = !pol;
            e.de = 1'b0;
        end else begin
            d    = k - pipe;
            hh   = d % 16;
            vv   = (d / 16) % 8;
            e.hs = (hh >= 10 && hh <= 12) ? pol : !pol;
            e.vs = (vv >= 5 && vv <= 6) ? pol : !pol;
            e.de = (hh < 8) && (vv < 4);
        end
        return e;
    endfunction

    // Returns at a negedge with rst low: that cycle is cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_tick, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_de} !== {1'b0, 4'd0, 3'd0, 5'b00110}) begin
            errors++;
            $display("FAIL reset_a: got tick=%b x=%0d y=%0d ls=%b fs=%b hs=%b vs=%b de=%b, required 0 0 0 0 0 1 1 0",
                     a_tick, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_de);
        end
        checks++;
        if ({b_tick, b_x, b_y, b_ls, b_fs, b_hs, b_vs, b_de} !== {1'b0, 4'd0, 3'd0, 5'b00000}) begin
            errors++;
            $display("FAIL reset_b: got tick=%b x=%0d y=%0d ls=%b fs=%b hs=%b vs=%b de=%b, required all 0",
                     b_tick, b_x, b_y, b_ls, b_fs, b_hs, b_vs, b_de);
        end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        int cyc = 0, last = 0, k = 0;
        int n_de = 0, n_ls = 0, n_fs = 0, n_hs = 0, n_vs = 0;
        exp_t e, got;
        do_reset();
        for (int i = 0; i < 129; i++) q_a.push_back(model(i, 0, 1'b0));
        while (q_a.size() > 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (a_tick) begin
                e   = q_a.pop_front();
                got = {a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_de};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL frame_tick %0d: got %h required %h", k, got, e);
                end
                checks++;
                if (cyc - last != 3) begin
                    errors++;
                    $display("FAIL tick_spacing %0d: got %0d cycles required 3", k, cyc - last);
                end
                last = cyc;
                if (k < 128) begin
                    n_de += int'(a_de);
                    n_ls += int'(a_ls);
                    n_fs += int'(a_fs);
                    n_hs += int'(!a_hs);
                    n_vs += int'(!a_vs);
                end
                k++;
            end else begin
                checks++;
                if (a_ls || a_fs) begin
                    errors++;
                    $display("FAIL strobe_width cycle %0d: got ls=%b fs=%b required 0 0", cyc, a_ls, a_fs);
                end
            end
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL frame_timeout: got %0d ticks required 129", k);
            q_a.delete();
        end
        checks++;
        if (n_de != 32) begin errors++; $display("FAIL de_count: got %0d required 32", n_de); end
        checks++;
        if (n_ls != 8) begin errors++; $display("FAIL line_start_count: got %0d required 8", n_ls); end
        checks++;
        if (n_fs != 1) begin errors++; $display("FAIL frame_start_count: got %0d required 1", n_fs); end
        checks++;
        if (n_hs != 24) begin errors++; $display("FAIL hsync_count: got %0d required 24", n_hs); end
        checks++;
        if (n_vs != 32) begin errors++; $display("FAIL vsync_count: got %0d required 32", n_vs); end
    endtask

    task automatic test_pipeline();
        int cyc = 0, k = 0;
        int c_origin = -1, c_de = -1, c_x10 = -1, c_hs = -1;
        exp_t e, got;
        do_reset();
        for (int i = 0; i < 131; i++) q_b.push_back(model(i, 3, 1'b1));
        while (q_b.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (c_de < 0 && b_de) c_de = cyc;
            if (c_hs < 0 && b_hs) c_hs = cyc;
            if (b_tick) begin
                if (c_origin < 0 && b_x == 4'd0 && b_y == 3'd0) c_origin = cyc;
                if (c_x10 < 0 && b_x == 4'd10) c_x10 = cyc;
                e   = q_b.pop_front();
                got = {b_x, b_y, b_ls, b_fs, b_hs, b_vs, b_de};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL pipe_tick %0d: got %h required %h", k, got, e);
                end
                k++;
            end
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL pipe_timeout: got %0d ticks required 131", k);
            q_b.delete();
        end
        checks++;
        if (c_de - c_origin != 3) begin
            errors++;
            $display("FAIL de_delay: got %0d cycles required 3", c_de - c_origin);
        end
        checks++;
        if (c_hs - c_x10 != 3) begin
            errors++;
            $display("FAIL hsync_delay: got %0d cycles required 3", c_hs - c_x10);
        end
    endtask

    task automatic test_polarity();
        int n_hs = 0, n_vs = 0;
        do_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            n_hs += int'(b_hs);
            n_vs += int'(b_vs);
        end
        checks++;
        if (n_hs != 24) begin errors++; $display("FAIL pol_hsync_high: got %0d required 24", n_hs); end
        checks++;
        if (n_vs != 32) begin errors++; $display("FAIL pol_vsync_high: got %0d required 32", n_vs); end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        int n = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (a_x == 4'd5 && a_y == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_reset_reach: got no x=5 y=3 required one"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({a_tick, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_de} !== {1'b0, 4'd0, 3'd0, 5'b00110}) begin
            errors++;
            $display("FAIL mid_reset_a: got tick=%b x=%0d y=%0d ls=%b fs=%b hs=%b vs=%b de=%b",
                     a_tick, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_de);
        end
        checks++;
        if ({b_tick, b_x, b_y, b_ls, b_fs, b_hs, b_vs, b_de} !== 12'd0) begin
            errors++;
            $display("FAIL mid_reset_b: got tick=%b x=%0d y=%0d ls=%b fs=%b hs=%b vs=%b de=%b",
                     b_tick, b_x, b_y, b_ls, b_fs, b_hs, b_vs, b_de);
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (a_tick) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL first_tick_latency: got %0d required 3", n); end
        checks++;
        if ({a_x, a_y, a_fs, a_ls} !== {4'd0, 3'd0, 2'b11}) begin
            errors++;
            $display("FAIL first_tick_coords: got x=%0d y=%0d fs=%b ls=%b required 0 0 1 1",
                     a_x, a_y, a_fs, a_ls);
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        bit seen = 1'b0;
        do_reset();
        repeat (384) @(negedge clk);
        checks++;
        if (b_fc !== 16'd3) begin errors++; $display("FAIL frame_cnt_3: got %0d required 3", b_fc); end
        force dut_b.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_b.frame_cnt_q;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b_fs) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || b_fc !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap: got %0d (strobe seen %b) required 0", b_fc, seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_pipeline();
        test_polarity();
        test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
